// File: rtl/hub75_rx_if.sv
// Frame-buffer write port driven by hub75_rx.
//   wr_en      : write strobe, one pixel per cycle while a row drains
//   wr_addr    : {row, col}
//   wr_data    : {b, g, r}
//   row_done   : one-cycle pulse after the last write of a row
//   frame_done : pulses with row_done when the last row of the frame was written
// master = receiver (drives), slave = frame buffer (consumes).
interface hub75_rx_if #(
  parameter int unsigned AW = 10
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          row_done;
  logic          frame_done;

  modport master (output wr_en, wr_addr, wr_data, row_done, frame_done);
  modport slave  (input  wr_en, wr_addr, wr_data, row_done, frame_done);
endinterface

// File: rtl/hub75_rx.sv
// HUB75 receiver: oversamples the panel shift clock, strobe, row select and serial RGB,
// rebuilds each row in a shift register and drains it into a frame-buffer write port.
// Ports:
//   clk, rst_n            : system clock (>= 4x hub_clk), async active-low reset
//   hub_clk, hub_stb      : HUB75 shift clock (rising edge samples data), latch strobe
//   hub_sel               : row select A..D (bit0 = A)
//   hub_r, hub_g, hub_b   : serial colour lines
//   err_clr               : single-cycle clear of the sticky error flags
//   wb                    : frame-buffer write port (wr_en/wr_addr/wr_data/row_done/frame_done)
//   err_count             : sticky, strobe seen with pixel count != ROWLEN
//   err_overrun           : sticky, strobe seen while a row was still draining
module hub75_rx #(
  parameter int unsigned ROWLEN      = 64,
  parameter int unsigned ROWS        = 16,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned SelW       = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hub_clk,
  input  logic            hub_stb,
  input  logic [SelW-1:0] hub_sel,
  input  logic            hub_r,
  input  logic            hub_g,
  input  logic            hub_b,
  input  logic            err_clr,
  hub75_rx_if.master      wb,
  output logic            err_count,
  output logic            err_overrun
);

  localparam int unsigned ColW = $clog2(ROWLEN);
  localparam int unsigned CntW = $clog2(ROWLEN + 2);
  localparam int unsigned InW  = SelW + 5;

  typedef enum logic {StIdle, StDrain} state_e;

  // Every input shares one synchronizer chain so data and clock stay aligned.
  logic [SYNC_STAGES-1:0][InW-1:0] sync_q;
  logic [InW-1:0]                  synced;
  logic                            prev_clk_q, prev_stb_q;
  logic                            clk_rise_q, stb_rise_q;
  logic [2:0]                      pix_q;
  logic [SelW-1:0]                 sel_q;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_clk_q <= 1'b0;
      prev_stb_q <= 1'b0;
      clk_rise_q <= 1'b0;
      stb_rise_q <= 1'b0;
      pix_q      <= '0;
      sel_q      <= '0;
    end else begin
      sync_q[0] <= {hub_sel, hub_b, hub_g, hub_r, hub_stb, hub_clk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_clk_q <= synced[0];
      prev_stb_q <= synced[1];
      // Rise pulses are registered together with the data/select they belong to.
      clk_rise_q <= synced[0] & ~prev_clk_q;
      stb_rise_q <= synced[1] & ~prev_stb_q;
      pix_q      <= synced[4:2];
      sel_q      <= synced[InW-1:5];
    end
  end

  // Datapath
  logic [ROWLEN-1:0][2:0] sr_q, sr_shift, latch_q;
  logic [CntW-1:0]        cnt_q, cnt_new;
  logic [SelW-1:0]        row_q;
  logic [ColW-1:0]        col_q;
  logic                   done_q, frame_q;
  logic                   err_count_q, err_overrun_q;
  state_e                 state_q, state_d;
  logic                   accept, overrun, last_col;

  // Newest pixel enters column 0; the first pixel of a full row ends up in column ROWLEN-1.
  // A shift in the strobe cycle is applied before the latch copy.
  always_comb begin
    sr_shift = sr_q;
    cnt_new  = cnt_q;
    if (clk_rise_q) begin
      sr_shift = {sr_q[ROWLEN-2:0], pix_q};
      if (cnt_q != CntW'(ROWLEN + 1)) cnt_new = cnt_q + 1'b1;
    end
  end

  assign accept   = stb_rise_q && (state_q == StIdle);
  assign overrun  = stb_rise_q && (state_q == StDrain);
  assign last_col = (col_q == ColW'(ROWLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q          <= '0;
      latch_q       <= '0;
      cnt_q         <= '0;
      row_q         <= '0;
      col_q         <= '0;
      done_q        <= 1'b0;
      frame_q       <= 1'b0;
      err_count_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      sr_q  <= sr_shift;
      cnt_q <= stb_rise_q ? '0 : cnt_new;
      if (accept) begin
        latch_q <= sr_shift;
        // Driver shifts the next row while sel still shows the current one.
        row_q   <= (sel_q == SelW'(ROWS - 1)) ? '0 : sel_q + 1'b1;
        col_q   <= '0;
      end else if (state_q == StDrain) begin
        col_q <= col_q + 1'b1;
      end
      done_q  <= (state_q == StDrain) && last_col;
      frame_q <= (state_q == StDrain) && last_col && (row_q == SelW'(ROWS - 1));
      // Set beats clear.
      if (stb_rise_q && (cnt_new != CntW'(ROWLEN))) err_count_q <= 1'b1;
      else if (err_clr)                             err_count_q <= 1'b0;
      if (overrun)      err_overrun_q <= 1'b1;
      else if (err_clr) err_overrun_q <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (stb_rise_q) state_d = StDrain;
      StDrain: if (last_col)   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    wb.wr_en   = 1'b0;
    wb.wr_addr = '0;
    wb.wr_data = '0;
    if (state_q == StDrain) begin
      wb.wr_en   = 1'b1;
      wb.wr_addr = {row_q, col_q};
      wb.wr_data = latch_q[col_q];
    end
    wb.row_done   = done_q;
    wb.frame_done = frame_q;
    err_count     = err_count_q;
    err_overrun   = err_overrun_q;
  end

endmodule

// File: tb/tb_hub75_rx.sv
module tb_hub75_rx;
  localparam int unsigned ROWLEN = 64;
  localparam int unsigned ROWS   = 16;
  localparam int unsigned SYNC   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hub_clk = 1'b0, hub_stb = 1'b0;
  logic [3:0] hub_sel = '0;
  logic       hub_r = 1'b0, hub_g = 1'b0, hub_b = 1'b0;
  logic       err_clr = 1'b0;
  logic       err_count, err_overrun;

  hub75_rx_if #(.AW(10)) wb ();

  hub75_rx #(.ROWLEN(ROWLEN), .ROWS(ROWS), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .hub_clk(hub_clk), .hub_stb(hub_stb), .hub_sel(hub_sel),
    .hub_r(hub_r), .hub_g(hub_g), .hub_b(hub_b), .err_clr(err_clr), .wb(wb),
    .err_count(err_count), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observed writes and pulses
  logic [12:0] wq[$];
  int rd_cnt = 0;
  int fd_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wb.wr_en) wq.push_back({wb.wr_addr, wb.wr_data});
      if (wb.row_done) rd_cnt++;
      if (wb.frame_done) fd_cnt++;
    end
  end

  // Reference model: every pixel shifted since reset; column c of a strobed row is the
  // c-th most recent pixel, or 0 if fewer than c+1 pixels exist.
  logic [2:0] hist[$];
  logic [2:0] snap[ROWLEN];

  task automatic take_snap();
    for (int c = 0; c < ROWLEN; c++)
      snap[c] = (c < hist.size()) ? hist[hist.size()-1-c] : 3'd0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_px(input logic [2:0] px);
    {hub_b, hub_g, hub_r} = px;
    hub_clk = 1'b0;
    cyc(3);
    hub_clk = 1'b1;
    hist.push_back(px);
    cyc(3);
    hub_clk = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] sel);
    hub_sel = sel;
    cyc(3);
    hub_stb = 1'b1;
    take_snap();
    cyc(3);
    hub_stb = 1'b0;
  endtask

  task automatic wait_rows(input int n, input string name);
    for (int i = 0; i < 400 && rd_cnt < n; i++) cyc(1);
    cyc(2);
    checks++;
    if (rd_cnt != n) begin
      errors++;
      $display("FAIL %s row_done count: got %0d want %0d", name, rd_cnt, n);
    end
  endtask

  task automatic clear_obs();
    wq.delete();
    rd_cnt = 0;
    fd_cnt = 0;
  endtask

  task automatic check_row(input logic [3:0] row, input string name);
    checks++;
    if (wq.size() != ROWLEN) begin
      errors++;
      $display("FAIL %s write count: got %0d want %0d", name, wq.size(), ROWLEN);
    end else begin
      for (int c = 0; c < ROWLEN; c++) begin
        logic [12:0] exp;
        exp = {row, 6'(c), snap[c]};
        checks++;
        if (wq[c] !== exp) begin
          errors++;
          $display("FAIL %s col %0d: got addr=%h data=%0d want addr=%h data=%0d", name, c,
                   wq[c][12:3], wq[c][2:0], exp[12:3], exp[2:0]);
        end
      end
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    cyc(3);
    checks++;
    if ({wb.wr_en, wb.wr_addr, wb.wr_data, wb.row_done, wb.frame_done, err_count,
         err_overrun} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got en=%b addr=%h data=%h rd=%b fd=%b ec=%b eo=%b want 0",
               wb.wr_en, wb.wr_addr, wb.wr_data, wb.row_done, wb.frame_done, err_count,
               err_overrun);
    end
    rst_n = 1'b1;
    cyc(3);
    checks++;
    if ({wb.wr_en, wb.row_done, err_count, err_overrun} !== 4'b0) begin
      errors++;
      $display("FAIL post-reset idle: got en=%b rd=%b ec=%b eo=%b want 0", wb.wr_en,
               wb.row_done, err_count, err_overrun);
    end
  endtask

  task automatic test_one_row();
    int n;
    clear_obs();
    for (int k = 0; k < ROWLEN; k++) shift_px(3'(k % 8));
    hub_sel = 4'd3;
    cyc(3);
    hub_stb = 1'b1;
    n = 0;
    while (!wb.wr_en && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != SYNC + 2) begin
      errors++;
      $display("FAIL latency: got %0d cycles want %0d", n, SYNC + 2);
    end
    cyc(1);
    hub_stb = 1'b0;
    // Expected straight from the row rule: column c holds pixel 63-c = (63-c) mod 8.
    for (int c = 0; c < ROWLEN; c++) snap[c] = 3'((ROWLEN - 1 - c) % 8);
    wait_rows(1, "one_row");
    check_row(4'd4, "one_row");
    checks++;
    if (fd_cnt != 0 || err_count !== 1'b0 || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL one_row flags: got fd=%0d ec=%b eo=%b want 0 0 0", fd_cnt, err_count,
               err_overrun);
    end
  endtask

  task automatic test_frame_wrap();
    for (int r = 0; r < 2; r++) begin
      logic [3:0] sel;
      sel = 4'(14 + r);
      clear_obs();
      for (int k = 0; k < ROWLEN; k++) shift_px(3'($urandom_range(0, 7)));
      strobe(sel);
      wait_rows(1, "frame_wrap");
      check_row((r == 0) ? 4'd15 : 4'd0, "frame_wrap");
      checks++;
      if (fd_cnt != ((r == 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL frame_wrap frame_done sel=%0d: got %0d want %0d", sel, fd_cnt,
                 (r == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_short_row();
    clear_obs();
    pulse_clr();
    for (int k = 0; k < ROWLEN - 4; k++) shift_px(3'($urandom_range(0, 7)));
    strobe(4'($urandom_range(0, ROWS - 1)));
    wait_rows(1, "short_row");
    check_row(4'((hub_sel + 1) % ROWS), "short_row");
    checks++;
    if (err_count !== 1'b1) begin
      errors++;
      $display("FAIL short_row err_count: got %b want 1", err_count);
    end
    pulse_clr();
    checks++;
    if (err_count !== 1'b0) begin
      errors++;
      $display("FAIL short_row err_clr: got %b want 0", err_count);
    end
  endtask

  task automatic test_long_row();
    clear_obs();
    pulse_clr();
    for (int k = 0; k < ROWLEN + 6; k++) shift_px(3'($urandom_range(0, 7)));
    strobe(4'($urandom_range(0, ROWS - 1)));
    wait_rows(1, "long_row");
    check_row(4'((hub_sel + 1) % ROWS), "long_row");
    checks++;
    if (err_count !== 1'b1) begin
      errors++;
      $display("FAIL long_row err_count: got %b want 1", err_count);
    end
  endtask

  task automatic test_overrun();
    clear_obs();
    pulse_clr();
    for (int k = 0; k < ROWLEN; k++) shift_px(3'($urandom_range(0, 7)));
    strobe(4'($urandom_range(0, ROWS - 1)));
    cyc(8);
    hub_stb = 1'b1;
    cyc(3);
    hub_stb = 1'b0;
    wait_rows(1, "overrun");
    cyc(150);
    check_row(4'((hub_sel + 1) % ROWS), "overrun");
    checks++;
    if (err_overrun !== 1'b1 || rd_cnt != 1) begin
      errors++;
      $display("FAIL overrun flags: got eo=%b rd=%0d want 1 1", err_overrun, rd_cnt);
    end
  endtask

  task automatic test_same_cycle_reset();
    logic [2:0] px;
    int n;
    clear_obs();
    pulse_clr();
    for (int k = 0; k < ROWLEN - 1; k++) shift_px(3'($urandom_range(0, 7)));
    px = 3'($urandom_range(0, 7));
    {hub_b, hub_g, hub_r} = px;
    hub_sel = 4'($urandom_range(0, ROWS - 1));
    cyc(3);
    hub_clk = 1'b1;
    hub_stb = 1'b1;
    hist.push_back(px);
    take_snap();
    cyc(3);
    hub_clk = 1'b0;
    hub_stb = 1'b0;
    cyc(1);
    checks++;
    if (err_count !== 1'b0 || wb.wr_en !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle: got ec=%b en=%b want 0 1", err_count, wb.wr_en);
    end
    n = 0;
    while (!(wb.wr_en && wb.wr_addr[5:0] == 6'd20) && n < 100) begin
      cyc(1);
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (wb.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain reset wr_en: got %b want 0", wb.wr_en);
    end
    checks++;
    if (wq.size() != 20) begin
      errors++;
      $display("FAIL mid_drain write count: got %0d want 20", wq.size());
    end else begin
      for (int c = 0; c < 20; c++) begin
        checks++;
        if (wq[c] !== {4'((hub_sel + 1) % ROWS), 6'(c), snap[c]}) begin
          errors++;
          $display("FAIL same_cycle col %0d: got %h want %h", c, wq[c],
                   {4'((hub_sel + 1) % ROWS), 6'(c), snap[c]});
        end
      end
    end
    hist.delete();
    cyc(3);
    rst_n = 1'b1;
    cyc(40);
    checks++;
    if (rd_cnt != 0 || wq.size() != 20) begin
      errors++;
      $display("FAIL mid_drain aftermath: got rd=%0d writes=%0d want 0 20", rd_cnt, wq.size());
    end
  endtask

  initial begin
    test_reset();
    test_one_row();
    test_frame_wrap();
    test_short_row();
    test_long_row();
    test_overrun();
    test_same_cycle_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Receive side of the HUB75 panel interface. Consumes the shift clock, strobe, row select and serial RGB lines that the matrix driver produces, and rebuilds each row.
- Writes each rebuilt row into a frame-buffer write port, one 3-bit pixel per cycle.
- Used for driver loopback self-test and for daisy-chain capture.
- All HUB75 inputs are asynchronous to clk and are oversampled.

Parameters:
- ROWLEN, 64, pixels shifted per row; number of hub_clk rising edges expected between strobes.
- ROWS, 16, rows per frame; hub_sel width is log2(ROWS).
- SYNC_STAGES, 2, synchronizer depth applied identically to every HUB75 input.

Ports:
- clk  in  1  system clock; must be at least 4x hub_clk frequency.
- rst_n  in  1  asynchronous active-low reset.
- hub_clk  in  1  HUB75 shift clock; data is sampled on its rising edge.
- hub_stb  in  1  HUB75 latch strobe; a rising edge ends the row.
- hub_sel  in  4  row select A..D (bit0 = A).
- hub_r  in  1  serial red.
- hub_g  in  1  serial green.
- hub_b  in  1  serial blue.
- err_clr  in  1  single-cycle clear of the sticky error flags.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  10  {row[3:0], col[5:0]}.
- wr_data  out  3  {b, g, r}.
- row_done  out  1  one-cycle pulse after the last write of a row.
- frame_done  out  1  one-cycle pulse, coincident with row_done, when row == ROWS-1.
- err_count  out  1  sticky: the strobe arrived with pixel count != ROWLEN.
- err_overrun  out  1  sticky: the strobe arrived while the previous row was still draining.

Behaviour:
- Reset (async assert, sync release): all outputs 0, pixel count 0, FSM in IDLE, synchronizers cleared.
- Input path: each HUB75 input passes through SYNC_STAGES flops, then a one-flop edge detector. Data lines use the same depth as hub_clk, so data and clock stay aligned.
- Shift:
  - On each synced hub_clk rise, push {b,g,r} into a ROWLEN x 3 shift register.
  - Increment the pixel count, saturating at ROWLEN+1.
  - The k-th pixel shifted (k from 0) lands at column ROWLEN-1-k.
- Strobe, on a synced hub_stb rise:
  - Copy the shift register into the row latch.
  - Set target row = (synced hub_sel + 1) mod ROWS. The driver presents data for the next row while sel still shows the current one.
  - If count != ROWLEN, set err_count. The row is still written; columns not shifted keep stale shift-register content.
  - Reset the pixel count to 0.
  - Shifting continues normally after the strobe.
- FSM states: IDLE, DRAIN.
  - IDLE -> DRAIN on a strobe rise.
  - In DRAIN, col runs 0..ROWLEN-1, one per cycle. wr_en=1, wr_addr={row,col}, wr_data=latch[col].
  - After col == ROWLEN-1: return to IDLE and pulse row_done the next cycle. frame_done pulses with it when row == ROWS-1.
- Latency: the first wr_en occurs SYNC_STAGES+2 cycles after the hub_stb input rises. The drain lasts exactly ROWLEN cycles.
- Overrun: a strobe rise during DRAIN is dropped and sets err_overrun. The latch, row and drain are unaffected. The pixel count still resets to 0.
- Simultaneous hub_clk rise and hub_stb rise in the same cycle: shift first, then latch. The pushed pixel is included in the row and in the count.
- Pixel-count saturation: counting stops at ROWLEN+1, so an over-long row reports err_count and the counter never wraps.
- Error flags:
  - err_clr clears both sticky flags.
  - If a set condition occurs in the same cycle as err_clr, set wins.
- Reset mid-drain: the drain aborts, wr_en drops immediately (async), and no row_done is issued.
- Row wrap: sel = ROWS-1 at the strobe targets row 0.

Test Plan:
- Reset then one row: sel=3, 64 hub_clk rises with pixel k = k mod 8, then a strobe -> 64 writes with addr {4, c}, data (63-c) mod 8. One row_done, no errors, no frame_done.
- Frame wrap: sel=14 then 15 with any data -> writes to row 15 then row 0. frame_done fires after the row-15 drain only.
- Short row: 60 clocks, then a strobe -> err_count=1, 64 writes still issued. err_clr -> err_count=0.
- Long row: 70 clocks, then a strobe -> err_count=1; cols 0..63 hold the last 64 pixels shifted.
- Overrun: a second strobe 10 cycles into a drain -> err_overrun=1, the first row completes all 64 writes, and no second drain occurs.
- Same-cycle edges and reset: hub_clk and hub_stb rise together as the 64th pixel -> count is 64, no error. Then assert rst_n=0 at drain col 20 -> wr_en=0 at once and no row_done follows.
